// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and FSM state encoding for the UART TX
//               scheduler. UART_PARITY_EN adds the PARITY state and stretches
//               the frame to 11 bit times.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
// ============================================================================
// Module      : uart_tx_sched_if
// Description : Requester-side bus of the UART TX scheduler (request, data,
//               grant, status and the serial line).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_sched_if #(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]   REQ;
  logic [8*NREQ-1:0] DATA;
  logic [NREQ-1:0]   GNT;
  logic [2:0]        GNT_ID;
  logic              BUSY;
  logic              TXD;

  modport master (
    output REQ, DATA,
    input  GNT, GNT_ID, BUSY, TXD
  );

  modport slave (
    input  REQ, DATA,
    output GNT, GNT_ID, BUSY, TXD
  );

endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module      : uart_baud_tick
// Description : K/2^N fractional phase accumulator; TICK is the registered
//               carry out, one CLK wide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int K = 1,
  parameter int N = 1
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  logic [N-1:0] r_acc;
  logic         r_tick;
  logic [N:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + (N+1)'(K);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_acc  <= w_sum[N-1:0];
      r_tick <= w_sum[N];
    end
  end

  assign TICK = r_tick;

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module      : uart_tx_sched
// Description : Round-robin arbiter sharing one 8N1 UART transmitter between
//               NREQ byte requesters. UART_PARITY_EN adds an even parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_sched #(
  parameter int K    = 1,
  parameter int N    = 1,
  parameter int NREQ = 4,
  parameter int OVS  = 16
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_sched_if.slave bus
);

  import uart_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(OVS);

  state_t                 r_state,  w_state_nxt;
  logic [PW-1:0]          r_ptr,    w_ptr_nxt;
  logic [NREQ-1:0]        r_gnt,    w_gnt_nxt;
  logic [2:0]             r_gnt_id, w_gnt_id_nxt;
  logic                   r_busy,   w_busy_nxt;
  logic                   r_txd,    w_txd_nxt;
  logic [DATA_BITS-1:0]   r_byte,   w_byte_nxt;
  logic [TW-1:0]          r_tcnt,   w_tcnt_nxt;
  logic [2:0]             r_bcnt,   w_bcnt_nxt;

  logic                   w_tick;
  logic                   w_bit_end;
  logic                   w_found;
  logic [PW-1:0]          w_pick;
  logic [PW-1:0]          w_idx;
  logic [DATA_BITS-1:0]   w_sel_byte;

  uart_baud_tick #(
    .K (K),
    .N (N)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (w_tick)
  );

  // Walk offsets from far to near so the nearest asserted request wins.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = '0;
    w_idx      = '0;
    w_sel_byte = '0;
    for (int j = NREQ-1; j >= 0; j--) begin
      w_idx = PW'((int'(r_ptr) + j) % NREQ);
      if (bus.REQ[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == PW'(i)) w_sel_byte = bus.DATA[8*i +: 8];
    end
  end

  assign w_bit_end = w_tick && (r_tcnt == TW'(OVS-1));

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_gnt_nxt    = '0;
    w_gnt_id_nxt = r_gnt_id;
    w_busy_nxt   = r_busy;
    w_txd_nxt    = r_txd;
    w_byte_nxt   = r_byte;
    w_tcnt_nxt   = r_tcnt;
    w_bcnt_nxt   = r_bcnt;

    if (w_tick && (r_state != IDLE)) w_tcnt_nxt = r_tcnt + TW'(1);

    case (r_state)
      IDLE: begin
        w_busy_nxt = 1'b0;
        w_txd_nxt  = 1'b1;
        if (w_found) begin
          w_state_nxt  = START;
          w_gnt_nxt    = NREQ'(1) << w_pick;
          w_gnt_id_nxt = 3'(w_pick);
          w_byte_nxt   = w_sel_byte;
          w_busy_nxt   = 1'b1;
          w_txd_nxt    = 1'b0;
          w_tcnt_nxt   = '0;
          w_bcnt_nxt   = '0;
          w_ptr_nxt    = PW'((int'(w_pick) + 1) % NREQ);
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_bcnt_nxt  = '0;
          w_txd_nxt   = r_byte[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bcnt == 3'(DATA_BITS-1)) begin
`ifdef UART_PARITY_EN
            w_state_nxt = PARITY;
            w_txd_nxt   = ^r_byte;
`else
            w_state_nxt = STOP;
            w_txd_nxt   = 1'b1;
`endif
          end else begin
            w_bcnt_nxt = r_bcnt + 3'd1;
            w_txd_nxt  = r_byte[r_bcnt + 3'd1];
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_txd_nxt   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_txd_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
      r_txd    <= 1'b1;
      r_byte   <= '0;
      r_tcnt   <= '0;
      r_bcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_busy   <= w_busy_nxt;
      r_txd    <= w_txd_nxt;
      r_byte   <= w_byte_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_bcnt   <= w_bcnt_nxt;
    end
  end

  assign bus.GNT    = r_gnt;
  assign bus.GNT_ID = r_gnt_id;
  assign bus.BUSY   = r_busy;
  assign bus.TXD    = r_txd;

endmodule

`default_nettype wire

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one 8N1 UART transmitter between NREQ byte requesters.
- Generates its own oversampling tick from a K/N phase accumulator, using the same fractional-divider scheme as the rest of the UART clocking.
- Grants one requester at a time, latches its byte and serialises it on TXD.
- Sits between the scoreboard logic (multiple byte sources) and the board TX pin.

Parameters:
- K, 1, phase-accumulator increment per CLK.
- N, 1, phase-accumulator width; tick rate = CLK*K/2^N.
- NREQ, 4, number of requesters (2..8).
- OVS, 16, ticks per UART bit (power of two, 4..16).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous, active-low reset.
- REQ  input  NREQ  per-requester byte-pending flag, level.
- DATA  input  8*NREQ  byte of requester i on DATA[8*i+7:8*i].
- GNT  output  NREQ  one-hot, one-cycle pulse: byte of that requester accepted.
- GNT_ID  output  3  index of the requester currently or last being transmitted.
- BUSY  output  1  high from grant cycle until the end of the stop bit.
- TXD  output  1  serial line, idle high.

Behaviour:
- Reset (RST=0, asynchronous): TXD=1, GNT=0, GNT_ID=0, BUSY=0, state=IDLE, accumulator=0, tick counter=0, bit counter=0, RR pointer=0. Applies immediately mid-frame; the partial frame is discarded and TXD returns high.
- Tick: acc <= acc+K each CLK (N bits, wraps). TICK = carry out of that addition, one CLK wide. With K=1 and N=1, TICK is high every 2nd cycle.
- States: IDLE, START, DATA, STOP.
- IDLE: if any REQ, the grant goes to the first asserted REQ searching from RR pointer upward (mod NREQ). In that cycle:
  - GNT[i]=1, byte latched, GNT_ID=i, BUSY=1.
  - tick counter cleared, RR pointer <= (i+1) mod NREQ.
  - next state START.
  - If no REQ, stay in IDLE with TXD=1.
- START: TXD=0. Leave after OVS ticks; tick counter counts 0..OVS-1, and on the tick at count OVS-1 it wraps and the state advances.
- DATA: TXD = latched byte, LSB first. Bit counter 0..7, each bit lasting OVS ticks; after bit 7 go to STOP.
- STOP: TXD=1 for OVS ticks, then go to IDLE with BUSY=0. IDLE lasts at least one cycle; the next grant is possible in the first IDLE cycle.
- Frame length: exactly 10*OVS ticks measured from the first tick after the grant. TXD must switch only on the cycle following a qualifying tick (registered output, no glitches).
- Handshake: a requester holds REQ and DATA stable until it sees GNT[i]; it must deassert REQ or present a new byte in the cycle after GNT. REQ changes while not granted are allowed. DATA of a granted requester is ignored after the grant cycle.
- Simultaneous REQ: only one GNT per frame. Every requester continuously asserting REQ is served within NREQ frames (no starvation).
- REQ deasserted during the grant cycle (same edge): the grant still stands, because it is decided on the sampled value.
- Outputs are registered except GNT, which is registered from the IDLE decision (high in the cycle after the REQ sample).

Optional Feature:
- UART_PARITY_EN defined: adds state PARITY between DATA and STOP. It drives the even parity of the latched byte (XOR of the 8 bits) for OVS ticks. Frame = 11*OVS ticks.
- Not defined: no PARITY state, 8N1 frame of 10*OVS ticks.

Decomposition:
- Package uart_pkg:
  - state encoding constants (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4; 3-bit vector).
  - DATA_BITS=8.
  - frame-length constant selected by UART_PARITY_EN.
- One sub-module, uart_baud_tick: parameters K, N; inputs CLK, RST; output TICK. Contains the accumulator and carry-out.
- Arbiter and FSM stay in uart_tx_sched.

Test Plan:
- Reset idle (K=1, N=1, OVS=16): hold RST low 5 cycles, release, no REQ for 200 cycles -> TXD=1, BUSY=0, GNT=0 throughout.
- Single byte: REQ[2]=1, DATA byte2=8'hA5 -> GNT=4'b0100 for one cycle, GNT_ID=2. TXD shows 0,1,0,1,0,0,1,0,1,1, each bit 32 CLK (OVS ticks of 2 cycles). BUSY falls 320 CLK after the first tick.
- Round robin: REQ=4'b1111 held, bytes 8'h00..8'h03 -> grant order 0,1,2,3,0. Each frame carries the matching byte, and an IDLE gap of at least 1 cycle separates frames.
- Pointer skip: after a grant to 1, REQ=4'b0001 only -> grant goes to 0. Then REQ=4'b1001 -> grant to 3 (pointer=1, search 1,2,3).
- Reset mid-frame: assert RST during DATA bit 4 -> TXD=1 and BUSY=0 asynchronously. After release, a new REQ[0] frame starts from the start bit and the grant goes to 0.
- UART_PARITY_EN: byte 8'h07 -> parity bit 1 after the data bits; frame = 352 CLK with K=1, N=1, OVS=16.
